// File: rtl/cory_s2s_arb_pkg.sv
// Shared types and helpers for the cory stream arbiters.
package cory_s2s_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // ceil(log2(n)), never below 1 so a 2-way arbiter still gets a 1-bit id
  function automatic int f_log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cory_rr_pick.sv
// Rotating priority encoder: first asserted req at or after (ptr+1) mod K.
module cory_rr_pick
  import cory_s2s_arb_pkg::*;
#(
  parameter  int K = 4,
  localparam int W = f_log2(K)
) (
  input  logic [K-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  always_comb begin
    logic [W-1:0] c;
    any = 1'b0;
    idx = '0;
    c   = ptr;
    // walk K candidates with an explicit wrap so indices >= K never appear
    for (int i = 0; i < K; i++) begin
      c = (c == W'(K - 1)) ? '0 : c + W'(1);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/cory_s2s_arb.sv
// Round-robin packet arbiter: K valid/ready masters share one converter input,
// grant held from first offer until the winner's last beat is accepted.
module cory_s2s_arb
  import cory_s2s_arb_pkg::*;
#(
  parameter  int K = 4,
  parameter  int A = 64,
  localparam int W = f_log2(K)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [K-1:0]   i_v,
  input  logic [K*A-1:0] i_d,
  input  logic [K-1:0]   i_l,
  output logic [K-1:0]   o_r,
  output logic           o_v,
  output logic [A-1:0]   o_d,
  output logic           o_l,
  output logic [W-1:0]   o_id,
  input  logic           i_r
);

  arb_state_e          state, state_nxt;
  logic [W-1:0]        r_gnt, r_ptr, pick_idx, gnt;
  logic                pick_any, gnt_v, gnt_l, fire_last, lock_en;
  logic [K-1:0][A-1:0] d_arr;

  assign d_arr = i_d;

  cory_rr_pick #(.K(K)) u_pick (
    .req (i_v),
    .ptr (r_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // IDLE arbitrates combinationally, so back-to-back packets have no bubble
  assign gnt       = (state == ARB_IDLE) ? pick_idx : r_gnt;
  assign gnt_v     = (state == ARB_IDLE) ? pick_any : i_v[gnt];
  assign gnt_l     = i_l[gnt];
  assign fire_last = gnt_v & i_r & gnt_l;
  // lock on offer, not accept, so o_d stays stable under back-pressure
  assign lock_en   = (state == ARB_IDLE) & pick_any & ~fire_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (lock_en)   state_nxt = ARB_LOCK;
      ARB_LOCK: if (fire_last) state_nxt = ARB_IDLE;
      default:                 state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt <= '0;
      r_ptr <= W'(K - 1);
    end else begin
      if (lock_en)   r_gnt <= pick_idx;
      if (fire_last) r_ptr <= gnt;
    end
  end

  // outputs forced quiet while reset is low, independent of the clock
  always_comb begin
    o_v  = 1'b0;
    o_d  = '0;
    o_l  = 1'b0;
    o_id = '0;
    o_r  = '0;
    if (reset_n) begin
      o_v      = gnt_v;
      o_d      = d_arr[gnt];
      o_l      = gnt_l;
      o_id     = gnt;
      o_r[gnt] = i_r;
    end
  end

endmodule

// File: tb/tb_cory_s2s_arb.sv
// Directed bench for cory_s2s_arb: bench-side masters, expected beats queued per step.
module tb_cory_s2s_arb;
  import cory_s2s_arb_pkg::*;

  localparam int K = 4;
  localparam int A = 64;
  localparam int W = f_log2(K);

  typedef struct packed {
    logic [W-1:0] id;
    logic [A-1:0] d;
    logic         l;
  } beat_t;

  logic           clk, reset_n, i_r, o_v, o_l;
  logic [K-1:0]   i_v, i_l, o_r;
  logic [K*A-1:0] i_d;
  logic [A-1:0]   o_d;
  logic [W-1:0]   o_id;

  cory_s2s_arb #(.K(K), .A(A)) dut (
    .clk(clk), .reset_n(reset_n), .i_v(i_v), .i_d(i_d), .i_l(i_l),
    .o_r(o_r), .o_v(o_v), .o_d(o_d), .o_l(o_l), .o_id(o_id), .i_r(i_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t        exp_q[$];
  logic [A-1:0] md[K][16];
  logic         ml[K][16];
  int           mcnt[K], mptr[K];
  logic [K-1:0] hold, acc;
  int           nchk, nfail;

  task automatic chk(input string tag, input logic [A-1:0] obs, input logic [A-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int k, input logic [A-1:0] d, input logic l);
    md[k][mcnt[k]] = d;
    ml[k][mcnt[k]] = l;
    mcnt[k]++;
  endtask

  task automatic push(input int k, input logic [A-1:0] d, input logic l);
    beat_t b;
    b.id = W'(k);
    b.d  = d;
    b.l  = l;
    exp_q.push_back(b);
  endtask

  // each master offers its current beat and holds it until accepted
  task automatic drive();
    for (int k = 0; k < K; k++) begin
      if (mptr[k] < mcnt[k] && !hold[k]) begin
        i_v[k]         = 1'b1;
        i_d[k*A +: A]  = md[k][mptr[k]];
        i_l[k]         = ml[k][mptr[k]];
      end else begin
        i_v[k]         = 1'b0;
        i_d[k*A +: A]  = '0;
        i_l[k]         = 1'b0;
      end
    end
  endtask

  task automatic sample();
    beat_t        e;
    logic [K-1:0] one;
    @(negedge clk);
    if (o_v && i_r) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", {63'd0, o_v}, '0);
      end else begin
        e   = exp_q.pop_front();
        one = 1;
        chk("beat_id",    A'(o_id), A'(e.id));
        chk("beat_data",  o_d, e.d);
        chk("beat_last",  A'(o_l), A'(e.l));
        chk("beat_ready", A'(o_r), A'(one << e.id));
      end
    end
    acc = o_r & i_v;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int k = 0; k < K; k++) if (acc[k]) mptr[k]++;
    drive();
  endtask

  // cycles until every queued beat appears; a stall shows as a cycle-count miss
  task automatic run(input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      sample();
      advance();
      n++;
    end
    chk(tag, A'(n), A'(exp_cycles));
  endtask

  initial begin
    nchk    = 0;
    nfail   = 0;
    reset_n = 1'b0;
    i_r     = 1'b1;
    hold    = '0;
    acc     = '0;
    i_v     = '0;
    i_l     = '0;
    i_d     = '0;
    for (int k = 0; k < K; k++) begin
      mcnt[k] = 0;
      mptr[k] = 0;
    end

    // reset with everyone requesting: outputs quiet
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < K; k++) load(k, 64'hA00 + 64'(k * 16 + j), 1'b1);
    drive();
    @(posedge clk);
    @(negedge clk);
    chk("rst_o_v",  A'(o_v), '0);
    chk("rst_o_r",  A'(o_r), '0);
    chk("rst_o_id", A'(o_id), '0);
    chk("rst_o_d",  o_d, '0);
    chk("rst_o_l",  A'(o_l), '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // single-beat packets from all four: 0,1,2,3,0,1,2,3 with no bubbles
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < K; k++) push(k, 64'hA00 + 64'(k * 16 + j), 1'b1);
    run(8, "rr_cycles");

    // 3-beat packet from 1; 0 arrives mid-packet and must wait
    load(1, 64'h10, 1'b0);
    load(1, 64'h11, 1'b0);
    load(1, 64'h12, 1'b1);
    push(1, 64'h10, 1'b0);
    push(1, 64'h11, 1'b0);
    push(1, 64'h12, 1'b1);
    push(0, 64'h0A, 1'b1);
    drive();
    sample();
    advance();
    load(0, 64'h0A, 1'b1);
    drive();
    sample();
    chk("lock_r0_low", A'(o_r[0]), '0);
    advance();
    run(2, "lock_cycles");

    // back-pressure: req 2 offer frozen, late req 0 waits
    i_r = 1'b0;
    load(2, 64'h20, 1'b1);
    push(2, 64'h20, 1'b1);
    push(0, 64'h0B, 1'b1);
    drive();
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("bp_o_v",  A'(o_v), 64'd1);
      chk("bp_o_id", A'(o_id), 64'd2);
      chk("bp_o_d",  o_d, 64'h20);
      chk("bp_o_r",  A'(o_r), '0);
      advance();
      if (c == 1) begin
        load(0, 64'h0B, 1'b1);
        drive();
      end
    end
    i_r = 1'b1;
    run(2, "bp_cycles");

    // bubble inside a locked packet from 3 while 1 waits
    load(3, 64'h30, 1'b0);
    load(3, 64'h31, 1'b0);
    load(3, 64'h32, 1'b1);
    push(3, 64'h30, 1'b0);
    push(3, 64'h31, 1'b0);
    push(3, 64'h32, 1'b1);
    push(1, 64'h1B, 1'b1);
    drive();
    sample();
    advance();
    hold[3] = 1'b1;
    load(1, 64'h1B, 1'b1);
    drive();
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("bubble_o_v",  A'(o_v), '0);
      chk("bubble_o_id", A'(o_id), 64'd3);
      chk("bubble_o_r",  A'(o_r), 64'h8);
      advance();
    end
    hold[3] = 1'b0;
    drive();
    run(3, "bubble_cycles");

    // async reset in the middle of a packet from 2
    load(2, 64'h40, 1'b0);
    load(2, 64'h41, 1'b0);
    load(2, 64'h42, 1'b1);
    push(2, 64'h40, 1'b0);
    drive();
    sample();
    advance();
    #1;
    chk("pre_rst_o_v", A'(o_v), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_o_v", A'(o_v), '0);
    chk("arst_o_r", A'(o_r), '0);
    chk("arst_q_empty", A'(exp_q.size()), '0);
    @(posedge clk);
    #1;
    mptr[2] = mcnt[2];
    load(2, 64'h50, 1'b1);
    load(0, 64'h0C, 1'b1);
    drive();
    reset_n = 1'b1;
    push(0, 64'h0C, 1'b1);
    push(2, 64'h50, 1'b1);
    run(2, "rst_restart_cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
